// File: rtl/mult_arb_pkg.sv
// Shared widths, latency and requester-id type for the two-port multiplier arbiter.
// No logic here; imported by mult_arbiter and signed_mult.
package mult_arb_pkg;
    localparam int NREQ     = 2;
    localparam int OP_W     = 8;
    localparam int RES_W    = 16;
    localparam int MULT_LAT = 2;

    typedef logic req_id_t;
endpackage

// File: rtl/signed_mult.sv
// Registered signed 8x8 multiplier, 2-cycle latency (operands in t, product in t+2).
// No handshake: the caller tracks validity alongside the data.
module signed_mult
    import mult_arb_pkg::*;
(
    output logic signed [RES_W-1:0] out,
    input  logic                    clk,
    input  logic signed [OP_W-1:0]  a,
    input  logic signed [OP_W-1:0]  b
);
    logic signed [OP_W-1:0]  r_a;
    logic signed [OP_W-1:0]  r_b;
    logic signed [RES_W-1:0] w_a_ext;
    logic signed [RES_W-1:0] w_b_ext;

    // Sign-extend before multiplying so the 16-bit product is exact.
    assign w_a_ext = {{(RES_W-OP_W){r_a[OP_W-1]}}, r_a};
    assign w_b_ext = {{(RES_W-OP_W){r_b[OP_W-1]}}, r_b};

    always_ff @(posedge clk) begin
        r_a <= a;
        r_b <= b;
        out <= w_a_ext * w_b_ext;
    end
endmodule

// File: rtl/mult_arbiter.sv
// Two requesters share one signed multiplier via round-robin; accept-to-result latency 3.
// Grants are credit-gated so each per-requester result FIFO can never overflow.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic signed [OP_W-1:0]  req_a0,
    input  logic signed [OP_W-1:0]  req_b0,
    input  logic signed [OP_W-1:0]  req_a1,
    input  logic signed [OP_W-1:0]  req_b1,
    output logic [NREQ-1:0]         res_valid,
    input  logic [NREQ-1:0]         res_ready,
    output logic signed [RES_W-1:0] res_data0,
    output logic signed [RES_W-1:0] res_data1,
    output logic                    busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;

    logic [NREQ-1:0]         w_elig;
    logic [NREQ-1:0]         w_grant;
    logic [NREQ-1:0]         w_pop;
    logic [NREQ-1:0]         w_push;
    logic [CW-1:0]           w_infl   [NREQ];
    logic [CW-1:0]           w_credit [NREQ];
    req_id_t                 w_gid;
    logic signed [OP_W-1:0]  w_a;
    logic signed [OP_W-1:0]  w_b;
    logic signed [RES_W-1:0] w_prod;

    logic [MULT_LAT-1:0]     r_vld;
    req_id_t                 r_id   [MULT_LAT];
    req_id_t                 r_ptr;
    logic [RES_W-1:0]        r_mem  [NREQ][FIFO_DEPTH];
    logic [PW-1:0]           r_wptr [NREQ];
    logic [PW-1:0]           r_rptr [NREQ];
    logic [CW-1:0]           r_cnt  [NREQ];

    // Credits count everything not yet popped: in the pipe plus buffered.
    always_comb begin
        w_elig = '0;
        w_pop  = '0;
        w_push = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_infl[i] = '0;
            for (int s = 0; s < MULT_LAT; s++) begin
                if (r_vld[s] && (r_id[s] == req_id_t'(i)))
                    w_infl[i] = w_infl[i] + CW'(1);
            end
            w_pop[i]    = res_valid[i] & res_ready[i];
            w_credit[i] = w_infl[i] + r_cnt[i] - CW'(w_pop[i]);
            w_elig[i]   = rst_n && req_valid[i] && (w_credit[i] < CW'(FIFO_DEPTH));
            w_push[i]   = r_vld[MULT_LAT-1] && (r_id[MULT_LAT-1] == req_id_t'(i));
        end
    end

    always_comb begin
        w_grant = '0;
        if (&w_elig)
            w_grant[r_ptr] = 1'b1;
        else
            w_grant = w_elig;
        w_gid = req_id_t'(w_grant[1]);
    end

    assign req_ready = w_grant;
    assign w_a       = w_gid ? req_a1 : req_a0;
    assign w_b       = w_gid ? req_b1 : req_b0;

    signed_mult u_mult (
        .out (w_prod),
        .clk (clk),
        .a   (w_a),
        .b   (w_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_ptr <= '0;
            for (int s = 0; s < MULT_LAT; s++)
                r_id[s] <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            r_vld   <= {r_vld[MULT_LAT-2:0], |w_grant};
            r_id[0] <= w_gid;
            for (int s = 1; s < MULT_LAT; s++)
                r_id[s] <= r_id[s-1];
            if (|w_grant)
                r_ptr <= ~w_gid;
            for (int i = 0; i < NREQ; i++) begin
                if (w_push[i])
                    r_wptr[i] <= r_wptr[i] + PW'(1);
                if (w_pop[i])
                    r_rptr[i] <= r_rptr[i] + PW'(1);
                r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
            end
        end
    end

    // Result storage carries no reset; validity comes from the counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (w_push[i])
                r_mem[i][r_wptr[i]] <= w_prod;
        end
    end

    always_comb begin
        res_valid = '0;
        for (int i = 0; i < NREQ; i++)
            res_valid[i] = (r_cnt[i] != '0);
    end

    assign busy      = (|r_vld) | (|res_valid);
    assign res_data0 = res_valid[0] ? r_mem[0][r_rptr[0]] : '0;
    assign res_data1 = res_valid[1] ? r_mem[1][r_rptr[1]] : '0;

    for (genvar g = 0; g < NREQ; g++) begin : g_chk
        a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
            w_push[g] |-> (r_cnt[g] < CW'(FIFO_DEPTH)));
    end

    a_grant_onehot: assert property (@(posedge clk) $onehot0(req_ready));
endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized bench for mult_arbiter: a queue-based model predicts grants, result timing and data.
module tb_mult_arbiter;
    localparam int D = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         req_valid = 2'b11;
    logic [1:0]         req_ready;
    logic signed [7:0]  req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [1:0]         res_valid;
    logic [1:0]         res_ready = 2'b00;
    logic signed [15:0] res_data0, res_data1;
    logic               busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt [2];

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } item_t;

    item_t q0[$];
    item_t q1[$];
    bit    prev_low = 1'b1;
    bit    rr_ptr = 1'b0;

    logic signed [7:0] ext_a [4] = '{8'sh80, 8'sh80, 8'sh7f, 8'sh00};
    logic signed [7:0] ext_b [4] = '{8'sh80, 8'sh7f, 8'sh7f, 8'shff};

    mult_arbiter #(.FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data0 (res_data0),
        .res_data1 (res_data1),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(logic signed [7:0] a, logic signed [7:0] b);
        int p;
        p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    // Model: each queue holds every accepted, not-yet-consumed product with its accept cycle.
    task automatic monitor_step();
        logic [1:0] ev;
        logic [1:0] pop;
        logic [1:0] elig;
        logic [1:0] er;
        int         sz [2];
        item_t      it;
        sz[0] = q0.size();
        sz[1] = q1.size();
        for (int i = 0; i < 2; i++)
            if (req_valid[i] && req_ready[i]) acc_cnt[i]++;
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 32'(0));
            if (prev_low) begin
                chk("rst_res_valid", 32'(res_valid), 32'(0));
                chk("rst_busy", 32'(busy), 32'(0));
                chk("rst_data0", 32'(res_data0[15:0]), 32'(0));
                chk("rst_data1", 32'(res_data1[15:0]), 32'(0));
            end
            q0.delete();
            q1.delete();
            rr_ptr   = 1'b0;
            prev_low = 1'b1;
        end else begin
            prev_low = 1'b0;
            ev = 2'b00;
            if (sz[0] > 0) ev[0] = (q0[0].cyc + 3 <= cyc);
            if (sz[1] > 0) ev[1] = (q1[0].cyc + 3 <= cyc);
            chk("res_valid", 32'(res_valid), 32'(ev));
            chk("busy", 32'(busy), 32'((sz[0] + sz[1]) > 0));
            if (ev[0]) chk("res_data0", 32'(res_data0[15:0]), 32'(q0[0].prod));
            if (ev[1]) chk("res_data1", 32'(res_data1[15:0]), 32'(q1[0].prod));
            pop = ev & res_ready;
            for (int i = 0; i < 2; i++)
                elig[i] = req_valid[i] && ((sz[i] - int'(pop[i])) < D);
            if (elig == 2'b11)
                er = rr_ptr ? 2'b10 : 2'b01;
            else
                er = elig;
            chk("req_ready", 32'(req_ready), 32'(er));
            if (pop[0]) void'(q0.pop_front());
            if (pop[1]) void'(q1.pop_front());
            if (er[0]) begin
                it.prod = ref_mul(req_a0, req_b0);
                it.cyc  = cyc;
                q0.push_back(it);
                rr_ptr = 1'b1;
            end
            if (er[1]) begin
                it.prod = ref_mul(req_a1, req_b1);
                it.cyc  = cyc;
                q1.push_back(it);
                rr_ptr = 1'b0;
            end
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        req_valid = 2'b00;
        repeat (n) tick();
    endtask

    task automatic rand_ops();
        req_a0 = 8'($urandom_range(0, 255));
        req_b0 = 8'($urandom_range(0, 255));
        req_a1 = 8'($urandom_range(0, 255));
        req_b1 = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int base;
        #1;
        chk("rst_req_ready_t0", 32'(req_ready), 32'(0));
        tick();
        tick();

        // single operation: -3 * 7
        rst_n     = 1'b1;
        res_ready = 2'b11;
        req_valid = 2'b01;
        req_a0    = -8'sd3;
        req_b0    = 8'sd7;
        tick();
        idle(6);

        // operand extremes on each requester
        for (int k = 0; k < 4; k++) begin
            req_valid = 2'b01;
            req_a0 = ext_a[k];
            req_b0 = ext_b[k];
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            req_valid = 2'b10;
            req_a1 = ext_a[k];
            req_b1 = ext_b[k];
            tick();
        end
        idle(6);

        // contention straight after reset
        rst_n = 1'b0;
        req_valid = 2'b11;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            rand_ops();
            tick();
        end
        idle(6);

        // backpressure on requester 0
        res_ready = 2'b10;
        req_valid = 2'b01;
        base = acc_cnt[0];
        for (int k = 0; k < 10; k++) begin
            rand_ops();
            tick();
        end
        chk("bp_accepts", 32'(acc_cnt[0] - base), 32'(4));
        chk("bp_stalled", 32'(req_ready), 32'(0));
        res_ready = 2'b11;
        base = acc_cnt[0];
        for (int k = 0; k < 10; k++) begin
            rand_ops();
            tick();
        end
        chk("bp_resume", 32'((acc_cnt[0] - base) >= 5), 32'(1));
        idle(8);

        // reset while two products are in flight
        base = acc_cnt[0];
        req_valid = 2'b01;
        rand_ops();
        tick();
        rand_ops();
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mf_accepts", 32'(acc_cnt[0] - base), 32'(2));
        idle(8);

        // random traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            req_valid = 2'($urandom_range(0, 3));
            res_ready[0] = ($urandom_range(0, 9) < 7);
            res_ready[1] = ($urandom_range(0, 9) < 7);
            rand_ops();
            tick();
        end
        rst_n = 1'b1;
        res_ready = 2'b11;
        idle(12);
        chk("final_idle", 32'(busy), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, result-buffer entries per requester (power of two, >= 4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req_valid  input  2  bit i: requester i presents operands.
REQ-005 req_ready  output  2  bit i: requester i granted this cycle (accept = valid & ready).
REQ-006 req_a0, req_b0  input  8 each  signed operands, requester 0.
REQ-007 req_a1, req_b1  input  8 each  signed operands, requester 1.
REQ-008 res_valid  output  2  bit i: res_data_i holds a valid product.
REQ-009 res_ready  input  2  bit i: requester i consumes the result (pop = valid & ready).
REQ-010 res_data0, res_data1  output  16 each  signed products, requesters 0 and 1.
REQ-011 busy  output  1  high while any product is in flight or buffered.

Function
REQ-012 One shared signed 8x8 multiplier, 2-cycle latency: operands driven in cycle t, product valid in cycle t+2.
REQ-013 At most one request accepted per cycle; req_ready is one-hot or zero and combinational from req_valid, credits and the priority pointer.
REQ-014 Eligibility: requester i eligible iff req_valid[i] and credit_i = inflight_i + fifo_count_i - pop_i < FIFO_DEPTH (same-cycle pop frees a credit).
REQ-015 Round-robin: if both eligible, grant goes to the pointer; after any grant the pointer moves to the other requester; with no grant it holds.
REQ-016 If only one requester is eligible, it is granted regardless of the pointer.
REQ-017 Granted operands are muxed to the multiplier in the accept cycle; a 2-stage valid+id shift register tracks each product.
REQ-018 Product leaving the multiplier in cycle t+2 is written to FIFO[id] at the end of t+2; res_valid[id] rises in cycle t+3 (accept-to-result latency 3).
REQ-019 Products are exact 16-bit two's-complement; no saturation or truncation.
REQ-020 Each FIFO is in-order; simultaneous push and pop in one cycle is legal and leaves the count unchanged.
REQ-021 The credit rule guarantees no FIFO overflow; a push into a full FIFO is a design error (assertion).
REQ-022 res_data_i is stable while res_valid[i]=1 and res_ready[i]=0.
REQ-023 With res_ready[i]=1 held, a lone requester sustains one accept per cycle.
REQ-024 busy = any pipeline stage valid OR any FIFO non-empty.

Reset
REQ-025 With rst_n=0 at a clock edge: pipeline valids, FIFO pointers and counts cleared, pointer set to requester 0.
REQ-026 During and after reset: req_ready=0 while rst_n=0, res_valid=0, busy=0, res_data0/1=0.
REQ-027 Reset mid-operation discards all in-flight and buffered products; none appears after rst_n rises.
REQ-028 Multiplier data registers need no reset; only valid/control state is reset.

Structure
REQ-029 Package mult_arb_pkg holds NREQ=2, OP_W=8, RES_W=16, MULT_LAT=2 and the requester-id typedef (1 bit).
REQ-030 One sub-module: signed_mult (registered signed 8x8 multiplier, ports out/clk/a/b, 2-cycle latency); arbiter, tag pipeline and both FIFOs inline in mult_arbiter.

Verification
REQ-031 Reset: rst_n=0 for 2 cycles with req_valid=2'b11 -> req_ready=0, res_valid=0, busy=0 throughout.
REQ-032 Single op: req0 a=-3, b=7 accepted cycle t, res_ready=2'b11 -> res_valid[0]=1 only in t+3, res_data0=16'hFFEB.
REQ-033 Contention: req_valid=2'b11 held after reset, res_ready=2'b11 -> grants alternate 0,1,0,1; each requester's products return in order.
REQ-034 Backpressure: res_ready[0]=0, req0 valid continuously, req1 idle -> exactly 4 accepts on req0, then req_ready[0]=0; raising res_ready[0] drains 4 results in order and resumes grants.
REQ-035 Extremes: (-128)*(-128) -> 16'h4000; (-128)*127 -> 16'hC080; 127*127 -> 16'h3F01; 0*(-1) -> 16'h0000.
REQ-036 Reset mid-flight: 2 accepts in consecutive cycles, rst_n=0 one cycle later -> no res_valid ever asserted for them; busy=0 after the reset edge.
